// File: rtl/pcounter_chk_pkg.sv
// Shared types for the pcounter_chk checker: datapath width, FSM states, mismatch entry.
// The entry gains a cycle timestamp when PCOUNTER_CHK_TSTAMP_EN is defined.
package pcounter_chk_pkg;

  localparam int DATA_W = 40;
  localparam int TS_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] exp;
    logic [DATA_W-1:0] act;
`ifdef PCOUNTER_CHK_TSTAMP_EN
    logic [TS_W-1:0]   tstamp;
`endif
  } err_entry_t;

endpackage

// File: rtl/pcounter_chk_fifo.sv
// Generic synchronous first-word-fall-through FIFO; head is visible the cycle after push.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
module pcounter_chk_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_pop;
  logic          do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_MAX);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pcounter_chk.sv
// Checks that each accepted counter input D yields D+1 on out_data one cycle later; optional PCOUNTER_CHK_TSTAMP_EN adds err_tstamp.
// Latency: compare 1 cycle after in_valid; err_ready backpressures the mismatch FIFO, full-FIFO mismatches are dropped and set overflow.
module pcounter_chk
  import pcounter_chk_pkg::*;
#(
  parameter int DATA_W      = pcounter_chk_pkg::DATA_W,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] out_data,
  output logic              err_valid,
  input  logic              err_ready,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_act,
`ifdef PCOUNTER_CHK_TSTAMP_EN
  output logic [31:0]       err_tstamp,
`endif
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              overflow,
  output logic              halted
);

  localparam logic [DATA_W-1:0] D_ONE = 1;
  localparam logic [CNT_W-1:0]  C_ONE = 1;

  state_e            state;
  state_e            state_nxt;
  logic              exp_v;
  logic [DATA_W-1:0] exp_q;
  logic              cmp_eq;
  logic              cmp_match;
  logic              cmp_mism;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop_ok;
  err_entry_t        push_ent;
  err_entry_t        head_ent;

  assign cmp_eq    = (exp_q == out_data);
  assign cmp_match = exp_v && cmp_eq;
  assign cmp_mism  = exp_v && !cmp_eq;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN: begin
        if (!enable)                              state_nxt = IDLE;
        else if ((STOP_ON_ERR != 0) && cmp_mism)  state_nxt = HALT;
      end
      HALT: if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign halted = (state == HALT);

  // Only RUN arms a new compare; one already armed still resolves after leaving RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_v <= 1'b0;
      exp_q <= '0;
    end else if (state == RUN) begin
      exp_v <= in_valid;
      exp_q <= in_data + D_ONE;
    end else begin
      exp_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      match_cnt    <= '0;
      mismatch_cnt <= '0;
    end else begin
      if (cmp_match && (match_cnt != '1))    match_cnt    <= match_cnt + C_ONE;
      if (cmp_mism  && (mismatch_cnt != '1)) mismatch_cnt <= mismatch_cnt + C_ONE;
    end
  end

  assign pop_ok = !fifo_empty && err_ready;

  always_ff @(posedge clk) begin
    if (!rst)                                  overflow <= 1'b0;
    else if (cmp_mism && fifo_full && !pop_ok) overflow <= 1'b1;
  end

`ifdef PCOUNTER_CHK_TSTAMP_EN
  logic [TS_W-1:0] tstamp_q;
  localparam logic [TS_W-1:0] T_ONE = 1;

  always_ff @(posedge clk) begin
    if (!rst) tstamp_q <= '0;
    else      tstamp_q <= tstamp_q + T_ONE;
  end

  always_comb begin
    push_ent        = '0;
    push_ent.exp    = exp_q;
    push_ent.act    = out_data;
    push_ent.tstamp = tstamp_q;
  end

  assign err_tstamp = head_ent.tstamp;
`else
  always_comb begin
    push_ent     = '0;
    push_ent.exp = exp_q;
    push_ent.act = out_data;
  end
`endif

  pcounter_chk_fifo #(
    .W     ($bits(err_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmp_mism),
    .push_dat (push_ent),
    .pop      (pop_ok),
    .head_dat (head_ent),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign err_valid = !fifo_empty;
  assign err_exp   = head_ent.exp;
  assign err_act   = head_ent.act;

endmodule

// File: tb/tb_pcounter_chk.sv
// Directed bench for pcounter_chk: u0 runs with STOP_ON_ERR=0, u1 with STOP_ON_ERR=1, both on the same stimulus.
module tb_pcounter_chk;

  localparam int DW = 40;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out_data;
  logic          err_ready;

  logic          ev0, ev1;
  logic [DW-1:0] ee0, ee1, ea0, ea1;
  logic [CW-1:0] mc0, mc1, xc0, xc1;
  logic          ov0, ov1, h0, h1;
`ifdef PCOUNTER_CHK_TSTAMP_EN
  logic [31:0]   ts0, ts1;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pcounter_chk #(.DATA_W(DW), .DEPTH(4), .CNT_W(CW), .STOP_ON_ERR(0)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .out_data(out_data), .err_valid(ev0), .err_ready(err_ready), .err_exp(ee0), .err_act(ea0),
`ifdef PCOUNTER_CHK_TSTAMP_EN
    .err_tstamp(ts0),
`endif
    .match_cnt(mc0), .mismatch_cnt(xc0), .overflow(ov0), .halted(h0)
  );

  pcounter_chk #(.DATA_W(DW), .DEPTH(4), .CNT_W(CW), .STOP_ON_ERR(1)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .out_data(out_data), .err_valid(ev1), .err_ready(err_ready), .err_exp(ee1), .err_act(ea1),
`ifdef PCOUNTER_CHK_TSTAMP_EN
    .err_tstamp(ts1),
`endif
    .match_cnt(mc1), .mismatch_cnt(xc1), .overflow(ov1), .halted(h1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs at a negedge, then advance to the next negedge (one posedge in between).
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [DW-1:0] o);
    in_valid = v;
    in_data  = d;
    out_data = o;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] all_ones;
    all_ones  = '1;
    rst       = 1'b0;
    enable    = 1'b0;
    err_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_data  = '0;
    @(negedge clk);
    step(0, 0, 0);

    chk("rst_err_valid", ev0, 0);
    chk("rst_err_exp",   ee0, 0);
    chk("rst_err_act",   ea0, 0);
    chk("rst_match",     mc0, 0);
    chk("rst_mismatch",  xc0, 0);
    chk("rst_overflow",  ov0, 0);
    chk("rst_halted",    h0,  0);
    chk("rst_halted_u1", h1,  0);

    rst    = 1'b1;
    enable = 1'b1;
    step(0, 0, 0);

    // Correct counter stream 0..9
    for (int i = 0; i < 10; i++) step(1, DW'(i), DW'(i));
    step(0, 0, 10);
    chk("stream_match",     mc0, 10);
    chk("stream_mismatch",  xc0, 0);
    chk("stream_err_valid", ev0, 0);

    // All-ones input wraps to zero
    step(1, all_ones, 0);
    step(0, 0, 0);
    chk("wrap_match",    mc0, 11);
    chk("wrap_mismatch", xc0, 0);

    // Single mismatch: expect 7, observe 5
    step(1, 6, 0);
    step(0, 0, 5);
    chk("mm_err_valid", ev0, 1);
    chk("mm_err_exp",   ee0, 7);
    chk("mm_err_act",   ea0, 5);
    chk("mm_mismatch",  xc0, 1);
    chk("mm_halted_u0", h0,  0);
    chk("mm_halted_u1", h1,  1);
    err_ready = 1'b1;
    step(0, 0, 0);
    err_ready = 1'b0;
    chk("mm_popped", ev0, 0);

    // Six mismatches into a 4-deep FIFO
    for (int j = 0; j < 6; j++) step(1, DW'(100 + j), 0);
    step(0, 0, 0);
    chk("ovf_mismatch", xc0, 7);
    chk("ovf_flag",     ov0, 1);
    chk("ovf_head_exp", ee0, 101);
    chk("ovf_head_act", ea0, 0);
    chk("ovf_match",    mc0, 11);

    // Pop and push together on a full FIFO
    step(1, 200, 0);
    err_ready = 1'b1;
    step(0, 0, 0);
    chk("pp_mismatch", xc0, 8);
    chk("pp_head1",    ee0, 102);
    step(0, 0, 0);
    chk("pp_head2",    ee0, 103);
    step(0, 0, 0);
    chk("pp_head3",    ee0, 104);
    step(0, 0, 0);
    chk("pp_head4",    ee0, 201);
    chk("pp_head4_act", ea0, 0);
    step(0, 0, 0);
    chk("pp_drained",  ev0, 0);
    err_ready = 1'b0;

    // Three entries pending, then reset
    step(1, 300, 0);
    step(1, 301, 0);
    step(1, 302, 0);
    step(0, 0, 0);
    chk("pre_rst_mismatch", xc0, 11);
    chk("pre_rst_valid",    ev0, 1);
    chk("pre_rst_head",     ee0, 301);
    rst = 1'b0;
    step(0, 0, 0);
    chk("mid_rst_err_valid", ev0, 0);
    chk("mid_rst_err_exp",   ee0, 0);
    chk("mid_rst_err_act",   ea0, 0);
    chk("mid_rst_match",     mc0, 0);
    chk("mid_rst_mismatch",  xc0, 0);
    chk("mid_rst_overflow",  ov0, 0);
    chk("mid_rst_halted_u1", h1,  0);
    rst = 1'b1;
    step(0, 0, 0);

    // Fill exactly to full, then pop+push: no overflow
    for (int j = 0; j < 5; j++) step(1, DW'(400 + j), 0);
    chk("full_mismatch", xc0, 4);
    chk("full_overflow", ov0, 0);
    chk("full_head",     ee0, 401);
    err_ready = 1'b1;
    step(0, 0, 0);
    err_ready = 1'b0;
    chk("fullpp_overflow", ov0, 0);
    chk("fullpp_mismatch", xc0, 5);
    chk("fullpp_head",     ee0, 402);

    rst = 1'b0;
    step(0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0);

    // STOP_ON_ERR instance halts on first mismatch
    step(1, 6, 0);
    step(0, 0, 0);
    chk("stop_halted",   h1,  1);
    chk("stop_mismatch", xc1, 1);
    chk("stop_head",     ee1, 7);
    step(1, 1, 0);
    step(1, 2, 0);
    step(0, 0, 0);
    chk("halt_no_count", xc1, 1);
    chk("halt_still",    h1,  1);
    chk("run_u0_counts", xc0, 3);
    chk("run_u0_halted", h0,  0);
    enable = 1'b0;
    step(0, 0, 0);
    chk("halt_exit", h1, 0);
    enable = 1'b1;
    step(0, 0, 0);
    step(1, 3, 0);
    step(0, 0, 0);
    chk("rerun_mismatch", xc1, 2);
    chk("rerun_halted",   h1,  1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pcounter_chk.md
Name: pcounter_chk

Overview:
- Downstream checking stage for the 40-bit increment counter.
- Taps the value driven into the counter's data_in and the counter's data_out, then checks that every accepted input D produces D+1 (mod 2^40) one clock later.
- Keeps match/mismatch statistics and queues mismatching pairs in a small FIFO, drained over a valid/ready port by the testbench or a CPU-side reader.

Parameters:
- DATA_W, 40, datapath width; must equal the counter width.
- DEPTH, 4, mismatch FIFO entries; power of two, 2..16.
- CNT_W, 16, width of the saturating statistics counters.
- STOP_ON_ERR, 0, 1 = enter HALT on the first mismatch.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-low. Sampled on posedge clk; rst==0 resets the block.
- enable  in  1  1 = checking active; 0 = return to IDLE.
- in_valid  in  1  in_data is being applied to the counter this cycle.
- in_data  in  DATA_W  value driven to the counter's data_in.
- out_data  in  DATA_W  counter's data_out.
- err_valid  out  1  mismatch entry available at the FIFO head.
- err_ready  in  1  consumer accepts the head entry.
- err_exp  out  DATA_W  expected value of the head entry.
- err_act  out  DATA_W  observed value of the head entry.
- match_cnt  out  CNT_W  passing comparisons, saturating.
- mismatch_cnt  out  CNT_W  failing comparisons, saturating.
- overflow  out  1  sticky: a mismatch was dropped because the FIFO was full.
- halted  out  1  FSM is in HALT.

Behaviour:
- Reset (rst==0 at a posedge):
  - FSM goes to IDLE; exp_v=0; FIFO empty.
  - err_valid=0, err_exp=0, err_act=0, match_cnt=0, mismatch_cnt=0, overflow=0, halted=0.
  - Reset mid-operation discards pending compares and FIFO contents; nothing is held.
- Expected-value stage: on each posedge in RUN:
  - exp_q <= in_data + 1, truncated to DATA_W, so all-ones wraps to 0.
  - exp_v <= in_valid.
  - Outside RUN, exp_v <= 0.
- Compare: at posedge t+1, if exp_v, compare exp_q with out_data.
  - The counter updates on the negedge between t and t+1, so latency is exactly 1 cycle.
  - Equal: match_cnt += 1.
  - Not equal: mismatch_cnt += 1 and push {exp_q, out_data} into the FIFO.
  - Both counters saturate at all-ones.
- FIFO full:
  - A push to a full FIFO is dropped and overflow sets; mismatch_cnt still increments.
  - A simultaneous pop and push when full succeeds; overflow is not set.
- Pop: an entry is removed when err_valid && err_ready at a posedge.
  - err_exp/err_act are taken directly from the head entry (first-word-fall-through), no bubble.
  - err_valid is high whenever the FIFO is non-empty, in any FSM state except reset.
- FSM states:
  - IDLE: enable=1 moves to RUN next cycle.
  - RUN: enable=0 moves to IDLE. A mismatch with STOP_ON_ERR=1 moves to HALT.
  - HALT: halted=1, no compares. Stays in HALT until enable=0, then goes to IDLE.
- Statistics and overflow persist across IDLE/HALT and clear only on reset.
- A compare pending when the FSM leaves RUN (exp_v=1) still completes in the following cycle.

Optional Feature:
- Macro: PCOUNTER_CHK_TSTAMP_EN.
- Defined:
  - A free-running 32-bit cycle counter (reset to 0, wraps) is stored with each FIFO entry.
  - Extra output port err_tstamp [31:0] carries the cycle number of the compare that failed.
- Undefined: no timestamp counter, no extra FIFO storage, no err_tstamp port.

Decomposition:
- Package pcounter_chk_pkg holds:
  - DATA_W default constant.
  - State enum state_e {IDLE, RUN, HALT}.
  - Entry struct err_entry_t {exp, act [, tstamp]}, with the tstamp field under the macro.
- Sub-module pcounter_chk_fifo: generic synchronous FWFT FIFO.
  - Parameterised on entry type/width and DEPTH.
  - Provides push, pop, full, empty.

Test Plan:
- Reset then enable; stream in_data 0,1,2,...,9 with a correct counter model -> match_cnt=10, mismatch_cnt=0, err_valid=0.
- in_data=40'hFF_FFFF_FFFF, out_data=0 next cycle -> counts as a match (wrap).
- Force out_data=40'h5 when 40'h7 is expected, STOP_ON_ERR=0 -> err_valid=1, err_exp=7, err_act=5, mismatch_cnt=1, FSM stays in RUN.
- Inject 6 mismatches with err_ready=0, DEPTH=4 -> 4 entries held, overflow=1, mismatch_cnt=6. Then pop with err_ready=1 on a full FIFO during a new mismatch -> no further overflow increment.
- STOP_ON_ERR=1, first mismatch -> halted=1 and later mismatches are not counted. enable=0 then 1 -> back in RUN.
- rst=0 for one cycle with 3 FIFO entries and counters nonzero -> all outputs zero next cycle.
